ps2_key_tracker: RTL and testbench

//  Converts the raw PS/2 set-2 byte stream from the keyboard interface into held-key levels for the paddle stage.

---
 rtl/ps2_key_tracker.sv | 137 +++++++++++++
 tb/tb_ps2_key_tracker.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_tracker.sv
`default_nettype none
// ps2_key_tracker: PS/2 set-2 byte stream -> held-key flags, paddle directions and event strobes.
// Rev 1.0
module ps2_key_tracker #(
  parameter int PREFIX_TIMEOUT = 500000,
  parameter int TO_W           = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] scan_code_i,
  input  logic       scan_ready_i,
  output logic [1:0] left_dir_o,
  output logic [1:0] right_dir_o,
  output logic [3:0] keys_held_o,
  output logic       restart_pulse_o,
  output logic       key_event_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXT     = 2'd1,
    BRK     = 2'd2,
    EXT_BRK = 2'd3
  } state_t;

  localparam logic [7:0]      C_E0      = 8'hE0;
  localparam logic [7:0]      C_F0      = 8'hF0;
  localparam logic [TO_W-1:0] C_TO_LAST = TO_W'(PREFIX_TIMEOUT - 1);

  state_t          state_q, state_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            rdy_q;
  logic [3:0]      held_q, held_d;
  logic [1:0]      left_q, left_d, right_q, right_d;
  logic            restart_q, restart_d;
  logic            event_q, event_d;
  logic            accept_w, complete_w, is_ext_w, is_brk_w;

  function automatic logic [1:0] resolve_dir(input logic up, input logic dn);
    return {dn & ~up, up & ~dn};
  endfunction

  assign accept_w = scan_ready_i & ~rdy_q;

  always_comb begin
    state_d    = state_q;
    to_cnt_d   = to_cnt_q;
    held_d     = held_q;
    restart_d  = 1'b0;
    event_d    = 1'b0;
    complete_w = 1'b0;
    is_ext_w   = 1'b0;
    is_brk_w   = 1'b0;

    if (accept_w) begin
      to_cnt_d = '0;
      unique case (state_q)
        IDLE: begin
          if (scan_code_i == C_E0)      state_d = EXT;
          else if (scan_code_i == C_F0) state_d = BRK;
          else                          complete_w = 1'b1;
        end
        EXT: begin
          if (scan_code_i == C_F0)      state_d = EXT_BRK;
          else if (scan_code_i == C_E0) state_d = EXT;
          else begin
            complete_w = 1'b1;
            is_ext_w   = 1'b1;
          end
        end
        BRK: begin
          complete_w = 1'b1;
          is_brk_w   = 1'b1;
        end
        EXT_BRK: begin
          complete_w = 1'b1;
          is_ext_w   = 1'b1;
          is_brk_w   = 1'b1;
        end
      endcase
    end else if (state_q == IDLE) begin
      to_cnt_d = '0;
    end else if (to_cnt_q == C_TO_LAST) begin
      // Abandon a dangling prefix silently
      state_d  = IDLE;
      to_cnt_d = '0;
    end else begin
      to_cnt_d = to_cnt_q + 1'b1;
    end

    if (complete_w) begin
      state_d = IDLE;
      event_d = 1'b1;
      unique case ({is_ext_w, scan_code_i})
        {1'b0, 8'h1D}: held_d[0] = ~is_brk_w;
        {1'b0, 8'h1B}: held_d[1] = ~is_brk_w;
        {1'b0, 8'h2D}: restart_d = ~is_brk_w;
        {1'b1, 8'h75}: held_d[2] = ~is_brk_w;
        {1'b1, 8'h72}: held_d[3] = ~is_brk_w;
        default: ;
      endcase
    end

    left_d  = resolve_dir(held_d[0], held_d[1]);
    right_d = resolve_dir(held_d[2], held_d[3]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      to_cnt_q  <= '0;
      rdy_q     <= 1'b0;
      held_q    <= '0;
      left_q    <= '0;
      right_q   <= '0;
      restart_q <= 1'b0;
      event_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      to_cnt_q  <= to_cnt_d;
      rdy_q     <= scan_ready_i;
      held_q    <= held_d;
      left_q    <= left_d;
      right_q   <= right_d;
      restart_q <= restart_d;
      event_q   <= event_d;
    end
  end

  assign left_dir_o      = left_q;
  assign right_dir_o     = right_q;
  assign keys_held_o     = held_q;
  assign restart_pulse_o = restart_q;
  assign key_event_o     = event_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_key_tracker.sv
`default_nettype none
// tb_ps2_key_tracker: scoreboard bench with directed scenarios and random byte stream.
// Rev 1.0
module tb_ps2_key_tracker;

  localparam int PT = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] scan_code = 8'h00;
  logic       scan_ready = 1'b0;
  logic [1:0] left_dir, right_dir;
  logic [3:0] keys_held;
  logic       restart_pulse, key_event;

  ps2_key_tracker #(.PREFIX_TIMEOUT(PT), .TO_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .scan_code_i(scan_code), .scan_ready_i(scan_ready),
    .left_dir_o(left_dir), .right_dir_o(right_dir), .keys_held_o(keys_held),
    .restart_pulse_o(restart_pulse), .key_event_o(key_event)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] l;
    logic [1:0] r;
    logic [3:0] h;
    logic       rs;
  } exp_t;

  exp_t exp_q[$];
  exp_t last_e = '0;
  int   n_chk = 0;
  int   n_fail = 0;

  // Reference model state: which keys are down and what prefixes are pending
  bit      w_dn, s_dn, up_dn, dn_dn;
  bit      pend_ext, pend_brk;
  longint  last_t = 0;

  function automatic logic [1:0] dir_of(input bit up, input bit dn);
    if (up && !dn) return 2'b01;
    if (dn && !up) return 2'b10;
    return 2'b00;
  endfunction

  task automatic model_reset();
    w_dn = 0; s_dn = 0; up_dn = 0; dn_dn = 0;
    pend_ext = 0; pend_brk = 0;
  endtask

  task automatic model_byte(input logic [7:0] c);
    longint now;
    longint gap;
    bit     mk;
    exp_t   e;
    now = $time;
    gap = (now - last_t) / 10;
    if ((pend_ext || pend_brk) && gap > PT) begin
      pend_ext = 0;
      pend_brk = 0;
    end
    last_t = now;
    if (c == 8'hE0 && !pend_brk) pend_ext = 1;
    else if (c == 8'hF0 && !pend_brk) pend_brk = 1;
    else begin
      mk = !pend_brk;
      e  = '0;
      if (!pend_ext) begin
        if (c == 8'h1D) w_dn = mk;
        if (c == 8'h1B) s_dn = mk;
        if (c == 8'h2D) e.rs = mk;
      end else begin
        if (c == 8'h75) up_dn = mk;
        if (c == 8'h72) dn_dn = mk;
      end
      e.h = {dn_dn, up_dn, s_dn, w_dn};
      e.l = dir_of(w_dn, s_dn);
      e.r = dir_of(up_dn, dn_dn);
      exp_q.push_back(e);
      pend_ext = 0;
      pend_brk = 0;
    end
  endtask

  task automatic send(input logic [7:0] c, input int hold, input int gap);
    @(negedge clk);
    scan_code  = c;
    scan_ready = 1'b1;
    @(posedge clk);
    model_byte(c);
    repeat (hold - 1) @(posedge clk);
    @(negedge clk);
    scan_ready = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic cmp(input string name, input exp_t e);
    exp_t a;
    a = '{l: left_dir, r: right_dir, h: keys_held, rs: restart_pulse};
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s @%0t: got l=%b r=%b held=%b rst=%b, want l=%b r=%b held=%b rst=%b",
               name, $time, a.l, a.r, a.h, a.rs, e.l, e.r, e.h, e.rs);
    end
  endtask

  // Monitor: each key_event pops one expectation; between events outputs must hold
  always @(negedge clk) begin
    if (rst_n) begin
      if (key_event) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_event @%0t: got key_event=1, want 0", $time);
        end else begin
          last_e = exp_q.pop_front();
          cmp("event", last_e);
          last_e.rs = 1'b0;
        end
      end else begin
        cmp("hold", last_e);
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  logic [7:0] pool [8];

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    cmp("reset_state", '0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: W make, then break
    send(8'h1D, 1, 10);
    send(8'hF0, 1, 2);
    send(8'h1D, 1, 3);
    // 2: up arrow and S together, then release up arrow
    send(8'hE0, 1, 1); send(8'h75, 1, 1);
    send(8'h1B, 1, 2);
    send(8'hE0, 1, 0); send(8'hF0, 1, 0); send(8'h75, 2, 2);
    // 3: W and S cancel, then release S
    send(8'h1D, 1, 2);
    send(8'hF0, 1, 1); send(8'h1B, 1, 2);
    send(8'hF0, 1, 1); send(8'h1D, 1, 2);
    // 4: long-held R, R typematic repeat, R break
    send(8'h2D, 5, 3);
    send(8'h2D, 1, 3);
    send(8'hF0, 1, 1); send(8'h2D, 1, 3);
    // Break of unheld key and unknown code
    send(8'hF0, 1, 1); send(8'h1B, 1, 2);
    send(8'h55, 1, 2);
    // 5: prefix timeout boundary: distance PT still extended, PT+1 abandoned
    send(8'hE0, 1, PT - 2); send(8'h75, 1, 2);
    send(8'hE0, 1, 0); send(8'hF0, 1, PT - 2); send(8'h75, 1, 2);
    send(8'hE0, 1, PT - 1); send(8'h75, 1, 2);
    send(8'hF0, 1, PT + 4); send(8'h1D, 1, 2);
    // 6: reset in the middle of E0 F0 with up arrow held
    send(8'hE0, 1, 1); send(8'h75, 1, 2);
    send(8'hE0, 1, 1); send(8'hF0, 1, 0);
    #3;
    rst_n = 1'b0;
    #1;
    cmp("async_reset", '0);
    model_reset();
    last_e = '0;
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b1;
    send(8'h75, 1, 3);

    pool = '{8'h1D, 8'h1B, 8'h2D, 8'h75, 8'h72, 8'hE0, 8'hF0, 8'h00};
    for (int i = 0; i < 300; i++) begin
      logic [7:0] c;
      c = pool[$urandom_range(0, 7)];
      if (c == 8'h00) c = 8'($urandom_range(0, 255));
      send(c, $urandom_range(1, 4), ($urandom_range(0, 9) == 0) ? $urandom_range(PT, PT + 6)
                                                                 : $urandom_range(0, 4));
    end

    repeat (PT + 5) @(negedge clk);
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL missing_events: got %0d pending, want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
